// File: rtl/io_pkg.sv
// Shared definitions for the p18240 I/O page: addresses, register select and STAT layout.
package io_pkg;

    localparam int IO_DW = 16;

    localparam logic [15:0] IO_SWLED = 16'h2000;
    localparam logic [15:0] IO_TCNT  = 16'h2001;
    localparam logic [15:0] IO_TCMP  = 16'h2002;
    localparam logic [15:0] IO_STAT  = 16'h2003;

    localparam int STAT_TEN   = 0;
    localparam int STAT_MATCH = 1;
    localparam int STAT_SWCHG = 2;
    localparam int STAT_MIEN  = 3;

    typedef enum logic [1:0] {
        REG_SWLED = 2'd0,
        REG_TCNT  = 2'd1,
        REG_TCMP  = 2'd2,
        REG_STAT  = 2'd3
    } io_reg_t;

    typedef struct packed {
        logic [11:0] rsvd;
        logic        match_ien;
        logic        sw_chg;
        logic        match;
        logic        tmr_en;
    } stat_t;

    function automatic logic is_io_addr(input logic [15:0] addr);
        return addr[15:2] == IO_SWLED[15:2];
    endfunction

    function automatic io_reg_t decode_reg(input logic [15:0] addr);
        io_reg_t sel;
        case (addr)
            IO_TCNT: sel = REG_TCNT;
            IO_TCMP: sel = REG_TCMP;
            IO_STAT: sel = REG_STAT;
            default: sel = REG_SWLED;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Bus-wide switch debouncer: the output follows the input only after DEB_CYCLES
// consecutive identical samples; any differing sample restarts the count.
module sw_debounce #(
    parameter int WIDTH      = 16,
    parameter int DEB_CYCLES = 16
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] i_sample,
    output logic [WIDTH-1:0] o_stable
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

    logic [WIDTH-1:0] r_last;
    logic [WIDTH-1:0] r_stable;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_run;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_run = CW'(1);
        if (i_sample == r_last) begin
            w_run = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_last   <= '0;
            r_cnt    <= '0;
            r_stable <= '0;
        end else begin
            r_last <= i_sample;
            r_cnt  <= w_run;
            if (w_run == CNT_MAX) r_stable <= i_sample;
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/tridrive.sv
// Active-low-enabled tri-state driver onto a shared bus.
module tridrive #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_en_L,
    inout  wire  [WIDTH-1:0] io_bus
);
    assign io_bus = i_en_L ? {WIDTH{1'bz}} : i_data;

endmodule

// File: rtl/io_bus_responder.sv
// I/O page responder (0x2000-0x2003): switches/LEDs, prescaled 16-bit timer, status/control.
// Define IO_DEBOUNCE_EN to insert sw_debounce after the switch synchronizer.
module io_bus_responder
    import io_pkg::*;
#(
    parameter int PRESCALE   = 4,
    parameter int DEB_CYCLES = 16
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic [IO_DW-1:0] memAddr,
    input  logic             re_L,
    input  logic             we_L,
    inout  wire  [IO_DW-1:0] dataBus,
    input  logic [IO_DW-1:0] SW,
    output logic [IO_DW-1:0] LEDR,
    output logic             ioHit,
    output logic             irq_L
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("io_bus_responder: PRESCALE must be >= 1");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("io_bus_responder: DEB_CYCLES must be >= 1");
    end

    logic [IO_DW-1:0] r_ledr;
    logic [IO_DW-1:0] r_tcnt;
    logic [IO_DW-1:0] r_tcmp;
    stat_t            r_stat;
    logic [PW-1:0]    r_presc;
    logic [IO_DW-1:0] r_sync1;
    logic [IO_DW-1:0] r_sync2;
    logic [IO_DW-1:0] r_sw_prev;

    logic [IO_DW-1:0] w_sw_sync;
    logic [IO_DW-1:0] w_wdata;
    logic [IO_DW-1:0] w_rdata;
    logic [IO_DW-1:0] w_tcnt_inc;
    logic [IO_DW-1:0] w_tcnt_nxt;
    logic [PW-1:0]    w_presc_nxt;
    stat_t            w_stat_nxt;
    io_reg_t          w_sel;
    logic             w_read_hit;
    logic             w_drv_en_L;
    logic             w_wr_ledr;
    logic             w_wr_tcnt;
    logic             w_wr_tcmp;
    logic             w_wr_stat;
    logic             w_tick;
    logic             w_match_set;
    logic             w_swchg_set;

    // Exactly one strobe must be active; both together is treated as no access.
    assign ioHit      = is_io_addr(memAddr) & (~re_L ^ ~we_L);
    assign w_sel      = decode_reg(memAddr);
    assign w_read_hit = ioHit & ~re_L & reset_L;
    assign w_drv_en_L = ~w_read_hit;
    assign w_wdata    = dataBus;

    assign w_wr_ledr = ioHit & ~we_L & (w_sel == REG_SWLED);
    assign w_wr_tcnt = ioHit & ~we_L & (w_sel == REG_TCNT);
    assign w_wr_tcmp = ioHit & ~we_L & (w_sel == REG_TCMP);
    assign w_wr_stat = ioHit & ~we_L & (w_sel == REG_STAT);

`ifdef IO_DEBOUNCE_EN
    sw_debounce #(
        .WIDTH      (IO_DW),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_sw_debounce (
        .clock    (clock),
        .reset_L  (reset_L),
        .i_sample (r_sync2),
        .o_stable (w_sw_sync)
    );
`else
    assign w_sw_sync = r_sync2;
`endif

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            REG_SWLED: w_rdata = w_sw_sync;
            REG_TCNT:  w_rdata = r_tcnt;
            REG_TCMP:  w_rdata = r_tcmp;
            REG_STAT:  w_rdata = r_stat;
            default:   w_rdata = '0;
        endcase
    end

    tridrive #(
        .WIDTH (IO_DW)
    ) u_bus_drv (
        .i_data (w_rdata),
        .i_en_L (w_drv_en_L),
        .io_bus (dataBus)
    );

    // Timer: the prescaler wraps to produce a tick; a TCNT write on a tick edge wins.
    assign w_tick     = r_stat.tmr_en && (r_presc == PRESC_MAX);
    assign w_tcnt_inc = r_tcnt + 16'd1;

    always_comb begin
        w_presc_nxt = '0;
        if (r_stat.tmr_en && !w_tick) w_presc_nxt = r_presc + PW'(1);

        w_tcnt_nxt = r_tcnt;
        if (w_wr_tcnt)   w_tcnt_nxt = w_wdata;
        else if (w_tick) w_tcnt_nxt = w_tcnt_inc;
    end

    assign w_match_set = w_tick && !w_wr_tcnt && (w_tcnt_inc == r_tcmp);
    assign w_swchg_set = (w_sw_sync != r_sw_prev);

    // Flags are write-one-to-clear, but a coincident set event keeps them at 1.
    always_comb begin
        w_stat_nxt      = r_stat;
        w_stat_nxt.rsvd = '0;
        if (w_wr_stat) begin
            w_stat_nxt.tmr_en    = w_wdata[STAT_TEN];
            w_stat_nxt.match_ien = w_wdata[STAT_MIEN];
            if (w_wdata[STAT_MATCH]) w_stat_nxt.match  = 1'b0;
            if (w_wdata[STAT_SWCHG]) w_stat_nxt.sw_chg = 1'b0;
        end
        if (w_match_set) w_stat_nxt.match  = 1'b1;
        if (w_swchg_set) w_stat_nxt.sw_chg = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_ledr    <= '0;
            r_tcnt    <= '0;
            r_tcmp    <= 16'hFFFF;
            r_stat    <= '0;
            r_presc   <= '0;
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sw_prev <= '0;
        end else begin
            r_sync1   <= SW;
            r_sync2   <= r_sync1;
            r_sw_prev <= w_sw_sync;
            if (w_wr_ledr) r_ledr <= w_wdata;
            if (w_wr_tcmp) r_tcmp <= w_wdata;
            r_tcnt  <= w_tcnt_nxt;
            r_presc <= w_presc_nxt;
            r_stat  <= w_stat_nxt;
        end
    end

    assign LEDR  = r_ledr;
    assign irq_L = ~((r_stat.match & r_stat.match_ien) | r_stat.sw_chg);

endmodule
